// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic MIPS instruction requests into 32-bit words
// and writes them to instruction memory at an auto-incrementing address.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   instr_count
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ENC = 2'd1, S_WR = 2'd2;
    localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [15:0]       imm_q, imm_d;
    logic [25:0]       target_q, target_d;
    logic [31:0]       word_q, word_d, enc_word;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d, enc_legal;

    assign full        = cnt_q == CAP;
    assign in_ready    = state_q == S_IDLE && !full && !start;
    assign busy        = state_q != S_IDLE;
    assign mem_we      = state_q == S_WR;
    assign mem_addr    = ptr_q;
    assign mem_wdata   = word_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

    // Fields an op does not use are dropped by construction of each word
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'd0;
        case (op_q)
            4'd0:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100000};
            4'd1:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100010};
            4'd2:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100100};
            4'd3:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100101};
            4'd4:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b101010};
            4'd5:    enc_word = {6'b100011, rs_q, rt_q, imm_q};
            4'd6:    enc_word = {6'b101011, rs_q, rt_q, imm_q};
            4'd7:    enc_word = {6'b001000, rs_q, rt_q, imm_q};
            4'd8:    enc_word = {6'b001100, rs_q, rt_q, imm_q};
            4'd9:    enc_word = {6'b000010, target_q};
            4'd10:   enc_word = {6'b000100, rs_q, rt_q, imm_q};
            4'd11:   enc_word = {6'b000101, rs_q, rt_q, imm_q};
            4'd12:   enc_word = 32'd0;
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        target_d = target_q;
        word_d   = word_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (start) begin
            state_d = S_IDLE;
            ptr_d   = BASE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid && in_ready) begin
                    op_d     = op;
                    rs_d     = rs;
                    rt_d     = rt;
                    rd_d     = rd;
                    imm_d    = imm;
                    target_d = target;
                    state_d  = S_ENC;
                end
                S_ENC: begin
                    word_d  = enc_word;
                    err_d   = err_q | !enc_legal;
                    state_d = enc_legal ? S_WR : S_IDLE;
                end
                S_WR: begin
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            target_q <= '0;
            word_q   <= '0;
            ptr_q    <= BASE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            target_q <= target_d;
            word_q   <= word_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a
// transaction-level reference model (ADDR_W=2, BASE_ADDR=0, capacity 4).
module tb_instr_encoder;
    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [3:0]    op = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          in_ready, mem_we, busy, full, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   instr_count;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .target(target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .full(full), .err(err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int FN[5]   = '{32, 34, 36, 37, 42};
    int OPC[16] = '{0, 0, 0, 0, 0, 35, 43, 8, 12, 2, 4, 5, 0, 0, 0, 0};

    // Model: stage 0 = waiting, 1 = accepted (encoding), 2 = writing
    int          m_stage = 0, m_ptr = 0, m_cnt = 0;
    bit          m_err = 0, m_legal = 0;
    logic [31:0] m_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_enc(input logic [3:0] o, input logic [4:0] s, t, d,
                                            input logic [15:0] i, input logic [25:0] tg);
        logic [31:0] w;
        if (o > 12) return {1'b0, 32'd0};
        if (o < 5) w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(FN[o]);
        else if (o == 9) w = (32'd2 << 26) | 32'(tg);
        else if (o == 12) w = 32'd0;
        else w = (32'(OPC[o]) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(i);
        return {1'b1, w};
    endfunction

    task automatic cycle(input bit v, input logic [3:0] o, input logic [4:0] s, t, d,
                         input logic [15:0] i, input logic [25:0] tg, input bit st);
        bit rdy;
        logic [32:0] e;
        in_valid = v; op = o; rs = s; rt = t; rd = d; imm = i; target = tg; start = st;
        #1;
        rdy = m_stage == 0 && m_cnt != CAP && !st;
        check("in_ready", in_ready, rdy);
        @(posedge clk); #1;
        if (st) begin
            m_stage = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (m_stage == 0) begin
            if (v && rdy) begin
                e = ref_enc(o, s, t, d, i, tg);
                m_legal = e[32];
                m_word  = e[31:0];
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            if (m_legal) m_stage = 2;
            else begin m_err = 1; m_stage = 0; end
        end else begin
            m_ptr = (m_ptr + 1) % (1 << AW); m_cnt++; m_stage = 0;
        end
        check("mem_we", mem_we, m_stage == 2);
        if (m_stage == 2) begin
            check("mem_addr", mem_addr, m_ptr);
            check("mem_wdata", mem_wdata, m_word);
        end
        check("err", err, m_err);
        check("instr_count", instr_count, m_cnt);
        check("full", full, m_cnt == CAP);
        check("busy", busy, m_stage != 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic restart();
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cnt"}, instr_count, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #12;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        cycle(1, 0, 1, 2, 3, 0, 0, 0);
        idle(1);
        check("add_word", mem_wdata, 32'h00221820);
        check("add_addr", mem_addr, 0);
        idle(1);
        check("add_count", instr_count, 1);

        cycle(1, 5, 29, 8, 0, 16'h0004, 0, 0);
        cycle(1, 11, 4, 5, 0, 16'hFFFF, 0, 0);
        check("lw_word", mem_wdata, 32'h8FA80004);
        cycle(1, 11, 4, 5, 0, 16'hFFFF, 0, 0);
        cycle(1, 11, 4, 5, 0, 16'hFFFF, 0, 0);
        cycle(1, 9, 0, 0, 0, 0, 26'h100, 0);
        check("bne_word", mem_wdata, 32'h1485FFFF);
        check("bne_addr", mem_addr, 2);
        cycle(1, 9, 0, 0, 0, 0, 26'h100, 0);
        cycle(1, 9, 0, 0, 0, 0, 26'h100, 0);
        idle(1);
        check("j_word", mem_wdata, 32'h08000100);
        check("j_addr", mem_addr, 3);
        idle(1);
        check("full_set", full, 1);
        cycle(1, 0, 1, 1, 1, 0, 0, 0);
        idle(3);
        check("full_hold_cnt", instr_count, 4);
        restart();
        check("start_full", full, 0);

        cycle(1, 12, 3, 0, 7, 0, 0, 0);
        idle(1);
        check("nop_word", mem_wdata, 32'h00000000);
        check("nop_addr", mem_addr, 0);
        idle(1);
        cycle(1, 8, 1, 2, 31, 16'h00FF, 0, 0);
        idle(1);
        check("andi_word", mem_wdata, 32'h302200FF);
        idle(1);
        cycle(1, 13, 1, 2, 3, 16'h1234, 0, 0);
        idle(1);
        check("illegal_err", err, 1);
        check("illegal_cnt", instr_count, 2);
        cycle(1, 7, 4, 6, 0, 16'h8001, 0, 0);
        idle(1);
        check("addi_word", mem_wdata, 32'h20868001);
        check("addi_err", err, 1);
        idle(1);
        restart();
        check("start_err", err, 0);

        cycle(1, 6, 2, 3, 0, 16'h0010, 0, 0);
        restart();
        check("start_cancel_we", mem_we, 0);
        idle(2);

        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 5'($urandom),
                  5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                  $urandom_range(0, 24) == 0);

        restart();
        cycle(1, 1, 9, 10, 11, 0, 0, 0);
        idle(1);
        check("pre_rst_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #2 rst_n = 1'b1;
        m_stage = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        @(posedge clk); #1;
        cycle(1, 3, 5, 6, 7, 0, 0, 0);
        idle(1);
        check("post_rst_word", mem_wdata, 32'h00A63825);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
